// File: rtl/main_memory_responder.sv
// Main-memory responder: fixed-latency block refill / write-back engine below the cache.
// Optional macro MEM_RANGE_CHECK_EN: out-of-range requests end with err instead of wrapping.
module main_memory_responder #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned LATENCY     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           wdata,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  output logic [31:0]           rdata,
  output logic                  rdata_valid,
  output logic                  done,
  output logic                  err
);
  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned BOFF_W = $clog2(BLOCK_WORDS);
  localparam int unsigned BLK_W  = IDX_W - BOFF_W;
  localparam int unsigned LAT_W  = $clog2(LATENCY + 1);
  localparam int unsigned AIDX_W = ADDR_WIDTH - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RD_BURST,
    S_WR_BURST,
    S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [LAT_W-1:0]  r_lat, w_lat_nxt;
  logic [BOFF_W-1:0] r_beat, w_beat_nxt;
  logic [BLK_W-1:0]  r_blk, w_blk_nxt;
  logic              r_we, w_we_nxt;
  logic              r_req_ready, w_req_ready_nxt;
  logic              r_wdata_ready, w_wdata_ready_nxt;
  logic              r_rdata_valid, w_rdata_valid_nxt;
  logic [31:0]       r_rdata, w_rdata_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
`ifdef MEM_RANGE_CHECK_EN
  logic              r_oor, w_oor_nxt;
`endif

  logic [31:0]       r_mem [DEPTH_WORDS];
  logic [AIDX_W-1:0] w_req_idx;
  logic              w_accept;
  logic              w_mem_we;
  logic              w_unused;

  assign w_req_idx = req_addr[ADDR_WIDTH-1:2];
  assign w_accept  = (r_state == S_IDLE) && r_req_ready && req_valid;
  assign w_mem_we  = (r_state == S_WR_BURST) && wdata_valid;
  // Byte-lane bits and (without range check) the upper index bits are intentionally ignored.
  assign w_unused  = ^req_addr;

  assign req_ready   = r_req_ready;
  assign wdata_ready = r_wdata_ready;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign done        = r_done;
  assign err         = r_err;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_lat         <= '0;
      r_beat        <= '0;
      r_blk         <= '0;
      r_we          <= 1'b0;
      r_req_ready   <= 1'b0;
      r_wdata_ready <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_rdata       <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
      r_oor         <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_lat         <= w_lat_nxt;
      r_beat        <= w_beat_nxt;
      r_blk         <= w_blk_nxt;
      r_we          <= w_we_nxt;
      r_req_ready   <= w_req_ready_nxt;
      r_wdata_ready <= w_wdata_ready_nxt;
      r_rdata_valid <= w_rdata_valid_nxt;
      r_rdata       <= w_rdata_nxt;
      r_done        <= w_done_nxt;
      r_err         <= w_err_nxt;
`ifdef MEM_RANGE_CHECK_EN
      r_oor         <= w_oor_nxt;
`endif
    end
  end

  // Backing store survives reset; committed write beats are never rolled back
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[{r_blk, r_beat}] <= wdata;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt       = r_state;
    w_lat_nxt         = r_lat;
    w_beat_nxt        = r_beat;
    w_blk_nxt         = r_blk;
    w_we_nxt          = r_we;
    w_req_ready_nxt   = 1'b0;
    w_wdata_ready_nxt = 1'b0;
    w_rdata_valid_nxt = 1'b0;
    w_done_nxt        = 1'b0;
    w_err_nxt         = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
    w_oor_nxt         = r_oor;
`endif

    unique case (r_state)
      S_IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (w_accept) begin
          w_state_nxt     = S_WAIT;
          w_req_ready_nxt = 1'b0;
          w_lat_nxt       = LAT_W'(LATENCY);
          w_beat_nxt      = '0;
          w_blk_nxt       = w_req_idx[IDX_W-1:BOFF_W];
          w_we_nxt        = req_we;
`ifdef MEM_RANGE_CHECK_EN
          w_oor_nxt       = (w_req_idx >= AIDX_W'(DEPTH_WORDS));
`endif
        end
      end
      S_WAIT: begin
        if (r_lat <= LAT_W'(1)) begin
          w_lat_nxt = '0;
`ifdef MEM_RANGE_CHECK_EN
          if (r_oor) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
          end else
`endif
          if (r_we) begin
            w_state_nxt       = S_WR_BURST;
            w_wdata_ready_nxt = 1'b1;
          end else begin
            w_state_nxt       = S_RD_BURST;
            w_rdata_valid_nxt = 1'b1;
          end
        end else begin
          w_lat_nxt = r_lat - LAT_W'(1);
        end
      end
      S_RD_BURST: begin
        if (r_beat == BOFF_W'(BLOCK_WORDS - 1)) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_beat_nxt        = r_beat + BOFF_W'(1);
          w_rdata_valid_nxt = 1'b1;
        end
      end
      S_WR_BURST: begin
        w_wdata_ready_nxt = 1'b1;
        if (wdata_valid) begin
          if (r_beat == BOFF_W'(BLOCK_WORDS - 1)) begin
            w_state_nxt       = S_DONE;
            w_done_nxt        = 1'b1;
            w_wdata_ready_nxt = 1'b0;
          end else begin
            w_beat_nxt = r_beat + BOFF_W'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt     = S_IDLE;
        w_req_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_rdata_nxt = w_rdata_valid_nxt ? r_mem[{w_blk_nxt, w_beat_nxt}] : r_rdata;
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench for main_memory_responder: stimulus queues expected beats/done with their
// cycle stamps, a negedge monitor pops and compares whenever rdata_valid or done is seen.
module tb_main_memory_responder;
  localparam int AW  = 32;
  localparam int DW  = 1024;
  localparam int BW  = 4;
  localparam int LAT = 10;

  typedef logic [BW-1:0][31:0] blk_t;
  typedef struct {
    bit          is_done;
    logic [31:0] data;
    bit          err;
    int          cyc;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   wdata;
  logic          wdata_valid;
  logic          wdata_ready;
  logic [31:0]   rdata;
  logic          rdata_valid;
  logic          done;
  logic          err;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  main_memory_responder #(
    .ADDR_WIDTH (AW),
    .DEPTH_WORDS(DW),
    .BLOCK_WORDS(BW),
    .LATENCY    (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .wdata      (wdata),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic blk_t beats4(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] c, input logic [31:0] d);
    blk_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  function automatic void mon_pop(input bit is_done);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_event @cyc %0d: got is_done=%0d rdata=0x%0h, expected no event",
               cyc, is_done, rdata);
      return;
    end
    e = sb.pop_front();
    check("event_kind", 64'(is_done), 64'(e.is_done));
    check("event_cycle", 64'(cyc), 64'(e.cyc));
    if (is_done) check("done_err", 64'(err), 64'(e.err));
    else         check("rdata_beat", 64'(rdata), 64'(e.data));
  endfunction

  // Monitor: decoupled from stimulus, samples on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (rdata_valid) mon_pop(1'b0);
      if (done)        mon_pop(1'b1);
    end
  end

  function automatic void push(input bit is_done, input logic [31:0] data, input bit e_err,
                               input int at);
    exp_t e;
    e.is_done = is_done;
    e.data    = data;
    e.err     = e_err;
    e.cyc     = at;
    sb.push_back(e);
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", 64'(req_ready), 64'd1);
  endtask

  task automatic issue(input bit we, input logic [31:0] addr, input bit hold, output int acc);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    @(posedge clk);
    #1;
    acc = cyc;
    check("req_ready_after_accept", 64'(req_ready), 64'd0);
    if (!hold) req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [31:0] addr, input blk_t d);
    int acc;
    issue(1'b0, addr, 1'b0, acc);
    for (int k = 0; k < BW; k++) push(1'b0, d[k], 1'b0, acc + LAT + k);
    push(1'b1, 32'd0, 1'b0, acc + LAT + BW);
    wait_idle();
  endtask

  task automatic do_write(input logic [31:0] addr, input blk_t d, input bit stall, input bit hold);
    int acc;
    int n = 0;
    issue(1'b1, addr, hold, acc);
    while (wdata_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wdata_ready_latency", 64'(cyc), 64'(acc + LAT));
    for (int k = 0; k < BW; k++) begin
      if (stall) begin
        wdata_valid = 1'b0;
        @(negedge clk);
      end
      wdata_valid = 1'b1;
      wdata       = d[k];
      if (k == BW - 1) push(1'b1, 32'd0, 1'b0, cyc + 1);
      @(negedge clk);
    end
    wdata_valid = 1'b0;
    wdata       = '0;
    if (hold) begin
      check("req_ready_held_low", 64'(req_ready), 64'd0);
      req_valid = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int n;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_addr    = '0;
    wdata       = '0;
    wdata_valid = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outputs", {req_ready, wdata_ready, rdata_valid, done, err, rdata}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 64'(req_ready), 64'd1);
    check("post_reset_quiet", {rdata_valid, done, err}, 64'd0);

    do_write(32'h50, beats4(32'h7, 32'h8, 32'h9, 32'hA), 1'b0, 1'b0);
    do_read (32'h50, beats4(32'h7, 32'h8, 32'h9, 32'hA));
    check("rdata_hold", 64'(rdata), 64'hA);
    do_read (32'h54, beats4(32'h7, 32'h8, 32'h9, 32'hA));

    do_write(32'h60, beats4(32'h11, 32'h12, 32'h13, 32'h14), 1'b1, 1'b1);
    do_read (32'h60, beats4(32'h11, 32'h12, 32'h13, 32'h14));

    do_write(32'h0, beats4(32'h21, 32'h22, 32'h23, 32'h24), 1'b0, 1'b0);

    // Abort a refill during its second beat
    issue(1'b0, 32'h50, 1'b0, acc);
    push(1'b0, 32'h7, 1'b0, acc + LAT);
    n = 0;
    while (cyc < acc + LAT + 1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("beat1_before_reset", {rdata_valid, rdata}, {1'b1, 32'h8});
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", {req_ready, wdata_ready, rdata_valid, done, err, rdata}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wait_idle();
    do_read(32'h50, beats4(32'h7, 32'h8, 32'h9, 32'hA));

`ifdef MEM_RANGE_CHECK_EN
    issue(1'b0, 32'h1000, 1'b0, acc);
    push(1'b1, 32'd0, 1'b1, acc + LAT);
    wait_idle();
    do_read(32'h0, beats4(32'h21, 32'h22, 32'h23, 32'h24));
`else
    do_read(32'h1000, beats4(32'h21, 32'h22, 32'h23, 32'h24));
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/main_memory_responder.md
Name: main_memory_responder

Overview:
- Main-memory side of the cache/memory interface: responds to block refill (read) and write-back (write) requests issued by the cache controller.
- Models a fixed access latency, then transfers one cache block as BLOCK_WORDS consecutive 32-bit beats.
- Sits below the cache inside memory_system and replaces the ad-hoc fixed-delay wait used today.

Parameters:
- ADDR_WIDTH, 32, byte-address width of req_addr.
- DEPTH_WORDS, 1024, backing store size in 32-bit words; power of two.
- BLOCK_WORDS, 4, words per cache block; power of two, at least 2.
- LATENCY, 10, rising edges from request acceptance to the first data beat; at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  cache presents a request.
- req_ready  out  1  responder can accept a request; high only in IDLE.
- req_we  in  1  1 = write-back, 0 = refill read; sampled at acceptance.
- req_addr  in  ADDR_WIDTH  byte address; sampled at acceptance.
- wdata  in  32  write-back beat data.
- wdata_valid  in  1  wdata holds a valid beat.
- wdata_ready  out  1  responder consumes write beats; high in WR_BURST.
- rdata  out  32  refill beat data.
- rdata_valid  out  1  rdata valid this cycle; no backpressure.
- done  out  1  one-cycle pulse when the transaction ends.
- err  out  1  one-cycle pulse with done on a range error; see Optional Feature.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- While rst_n is low, all outputs are 0 (req_ready included) and the FSM is held in IDLE. After release, req_ready = 1.
- Reset does not clear the backing store. The store is zero-initialised at time 0 only.
- Acceptance: a request is accepted on a rising edge with req_valid && req_ready. req_valid is ignored in all other states.
- Address capture: word index = req_addr >> 2. The base is aligned down to a BLOCK_WORDS boundary, i.e. the low log2(BLOCK_WORDS) bits of the index are cleared. req_addr[1:0] is ignored.
- IDLE: req_ready = 1. On acceptance, load latency counter = LATENCY and go to WAIT.
- WAIT: the counter decrements each edge. The edge that reaches 0 moves the FSM to RD_BURST (req_we = 0) or WR_BURST (req_we = 1).
- Latency: the first beat slot occurs exactly LATENCY edges after the acceptance edge.
- RD_BURST: rdata_valid = 1 for exactly BLOCK_WORDS consecutive cycles. Beat k carries mem[base + k], k = 0 .. BLOCK_WORDS-1, with no gaps. After the last beat, go to DONE.
- WR_BURST: wdata_ready = 1. Each edge with wdata_valid = 1 writes wdata to mem[base + beat] and increments beat. Cycles with wdata_valid = 0 stall the burst and write nothing. After beat BLOCK_WORDS-1 is written, go to DONE.
- DONE: done = 1 for one cycle, then IDLE. req_ready returns to 1 on the cycle after done.
- Beat and latency counters are cleared at every acceptance.
- rdata holds its last value when rdata_valid = 0. It is 0 after reset.
- Address wrap (macro off): index arithmetic is modulo DEPTH_WORDS, so out-of-range addresses alias into the store.
- Back-to-back requests: minimum spacing is LATENCY + BLOCK_WORDS + 2 cycles between acceptance edges.
- Reset mid-transaction: the transaction is aborted immediately and all outputs go to 0. Write beats already committed stay in memory.

Optional Feature:
- Macro: MEM_RANGE_CHECK_EN.
- Defined: at acceptance, if word index >= DEPTH_WORDS, the request is still accepted and WAIT runs the full LATENCY. The FSM then goes directly to DONE with err = 1 alongside done. No rdata_valid beats, wdata_ready stays 0 and memory is unchanged.
- Undefined: no range compare; addresses wrap modulo DEPTH_WORDS; err is tied to 0.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles mid-simulation -> all outputs 0 asynchronously. After release, req_ready = 1; done, rdata_valid and err stay 0.
- Write-back then refill at 0x50 (LATENCY = 10, BLOCK_WORDS = 4):
  - Write beats 0x7, 0x8, 0x9, 0xA -> wdata_ready rises 10 edges after acceptance; one done pulse after the 4th beat.
  - Read of 0x50 -> rdata_valid high for 4 consecutive cycles carrying 0x7, 0x8, 0x9, 0xA, the first 10 edges after acceptance.
- Unaligned refill at 0x54 after the above -> beats start at aligned base 0x50: 0x7, 0x8, 0x9, 0xA.
- Write-back at 0x60 with wdata_valid low on alternate cycles, beats 0x11 to 0x14 -> only valid beats are written and done follows the 4th valid beat. A read of 0x60 returns 0x11, 0x12, 0x13, 0x14. req_valid held high during the burst is not accepted again.
- Reset during the 2nd beat of a read burst -> rdata_valid drops at once and no done pulse occurs. After release, a read of 0x50 still returns 0x7 to 0xA.
- Range check, addr 0x1000 (index 1024, DEPTH_WORDS = 1024):
  - With MEM_RANGE_CHECK_EN -> done and err pulse together 10 edges after acceptance; no rdata_valid.
  - Without the macro -> a read aliases to index 0 and returns mem[0..3].
